// File: rtl/bus_pkg.sv
// Shared constants and helper functions for the round-robin N-master x M-slave bus.
package bus_pkg;

   localparam int AW_DEF = 8;
   localparam int DW_DEF = 32;

   function automatic int clog2(input int n);
      int v;
      int r;
      v = n - 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >>> 1;
      end
      return r;
   endfunction

   // Returns the index of the highest set bit; callers pass one-hot vectors of up to 32 bits.
   function automatic int onehot_to_idx(input logic [31:0] oh);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant that parks on the last owner.
// Optional hold timeout is enabled by defining BUS_TIMEOUT_EN.
module bus_rr_arbiter
   import bus_pkg::*;
#(
   parameter int NUM_M    = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NUM_M-1:0] i_req,
   output logic [NUM_M-1:0] o_grant
);

   localparam int OW = (NUM_M > 1) ? clog2(NUM_M) : 1;

   // req/grant: a master raises its req bit and keeps its address, strobe and data stable;
   // it owns the path in every cycle its grant bit is high, one cycle after the request.
   logic [NUM_M-1:0]   r_grant;
   logic [NUM_M-1:0]   w_next_grant;
   logic [OW-1:0]      w_owner;
   logic [OW-1:0]      w_next_owner;
   logic [2*NUM_M-1:0] w_req_dbl;
   logic [NUM_M-1:0]   w_req_rot;
   logic               w_own_req;
   logic               w_found;
   logic               w_expire;
   int                 w_cand;

   assign w_owner   = OW'(onehot_to_idx(32'(r_grant)));
   assign w_req_dbl = {i_req, i_req};
   // Bit k of the rotated vector is the request of master (owner + k) mod NUM_M.
   assign w_req_rot = NUM_M'(w_req_dbl >> w_owner);
   assign w_own_req = w_req_rot[0];

   always_comb begin
      w_found      = 1'b0;
      w_next_owner = w_owner;
      w_cand       = 0;
      for (int k = 1; k < NUM_M; k++) begin
         if (!w_found && w_req_rot[k]) begin
            w_found = 1'b1;
            w_cand  = int'(w_owner) + k;
            if (w_cand >= NUM_M) w_cand = w_cand - NUM_M;
            w_next_owner = OW'(w_cand);
         end
      end
      if (w_own_req && !w_expire) w_next_owner = w_owner;
      w_next_grant = NUM_M'(1) << w_next_owner;
   end

`ifdef BUS_TIMEOUT_EN
   localparam int HW = (clog2(MAX_HOLD + 1) > 0) ? clog2(MAX_HOLD + 1) : 1;

   logic [HW-1:0] r_hold_cnt;
   logic          w_others;

   assign w_others = |(i_req & ~r_grant);
   assign w_expire = w_own_req && w_others && (r_hold_cnt == HW'(MAX_HOLD - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold_cnt <= '0;
      end else if ((w_next_owner != w_owner) || !w_others) begin
         r_hold_cnt <= '0;
      end else if (w_own_req) begin
         r_hold_cnt <= r_hold_cnt + 1'b1;
      end
   end
`else
   // Holding never expires in this build; MAX_HOLD is non-negative so this is constant 0.
   assign w_expire = (MAX_HOLD < 0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant <= NUM_M'(1);
      end else begin
         r_grant <= w_next_grant;
      end
   end

   assign o_grant = r_grant;

endmodule

// File: rtl/bus_rr_nxm.sv
// Shared NUM_M x NUM_S bus: round-robin arbitration, region decode, 1-cycle read return.
// Define BUS_TIMEOUT_EN to force rotation after MAX_HOLD contended cycles.
module bus_rr_nxm
   import bus_pkg::*;
#(
   parameter int NUM_M       = 4,
   parameter int NUM_S       = 4,
   parameter int AW          = AW_DEF,
   parameter int DW          = DW_DEF,
   parameter int REGION_BITS = 5,
   parameter int MAX_HOLD    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_M-1:0]    m_req,
   input  logic [NUM_M-1:0]    m_wr,
   input  logic [NUM_M*AW-1:0] m_address,
   input  logic [NUM_M*DW-1:0] m_dout,
   input  logic [NUM_S*DW-1:0] s_dout,
   output logic [NUM_M-1:0]    m_grant,
   output logic [DW-1:0]       m_din,
   output logic                m_err,
   output logic [NUM_S-1:0]    s_sel,
   output logic [AW-1:0]       s_address,
   output logic                s_wr,
   output logic [DW-1:0]       s_din
);

   localparam int IW = AW - REGION_BITS;

   logic [NUM_M-1:0] w_grant;
   logic [AW-1:0]    w_addr;
   logic             w_wr;
   logic [DW-1:0]    w_wdata;
   logic [IW-1:0]    w_idx;
   logic             w_miss;
   logic [NUM_S-1:0] w_sel;
   logic [NUM_S-1:0] r_sel;
   logic             r_miss;

   bus_rr_arbiter #(
      .NUM_M    (NUM_M),
      .MAX_HOLD (MAX_HOLD)
   ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .i_req   (m_req),
      .o_grant (w_grant)
   );

   assign m_grant = w_grant;

   // The grant is one-hot, so an AND-OR mux picks exactly the owner's fields.
   always_comb begin
      w_addr  = '0;
      w_wr    = 1'b0;
      w_wdata = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (w_grant[i]) begin
            w_addr  = w_addr  | m_address[i*AW +: AW];
            w_wr    = w_wr    | m_wr[i];
            w_wdata = w_wdata | m_dout[i*DW +: DW];
         end
      end
   end

   assign s_address = w_addr;
   assign s_wr      = w_wr;
   assign s_din     = w_wdata;

   assign w_idx  = w_addr[AW-1:REGION_BITS];
   assign w_miss = (32'(w_idx) >= NUM_S);

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NUM_S; i++) begin
         if (32'(w_idx) == 32'(i)) w_sel[i] = 1'b1;
      end
   end

   assign s_sel = w_sel;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sel  <= '0;
         r_miss <= 1'b0;
      end else begin
         r_sel  <= w_sel;
         r_miss <= w_miss;
      end
   end

   // A cleared select (reset or decode miss) returns zero read data.
   always_comb begin
      m_din = '0;
      for (int i = 0; i < NUM_S; i++) begin
         if (r_sel[i]) m_din = m_din | s_dout[i*DW +: DW];
      end
   end

   assign m_err = r_miss;

endmodule

// File: tb/tb_bus_rr_nxm.sv
// Self-checking bench for bus_rr_nxm: grant table, read-return scoreboard, reset and hold cases.
module tb_bus_rr_nxm;

   localparam int NM = 4;
   localparam int NS = 4;
   localparam int AW = 8;
   localparam int DW = 32;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [NM-1:0]       m_req;
   logic [NM-1:0]       m_wr;
   logic [NM*AW-1:0]    m_address;
   logic [NM*DW-1:0]    m_dout;
   logic [NS*DW-1:0]    s_dout;
   logic [NM-1:0]       m_grant;
   logic [DW-1:0]       m_din;
   logic                m_err;
   logic [NS-1:0]       s_sel;
   logic [AW-1:0]       s_address;
   logic                s_wr;
   logic [DW-1:0]       s_din;

   int total = 0;
   int bad   = 0;

   logic [DW:0]   exp_q[$];
   logic [DW-1:0] sdout_m[NS];
   logic [AW-1:0] mst_addr[NM];
   logic [NM-1:0] cur_grant;

   typedef struct {
      logic [NM-1:0] req;
      logic [NM-1:0] exp_grant;
   } vec_t;

   vec_t vecs[11];

   bus_rr_nxm dut (
      .clk       (clk),
      .reset     (reset),
      .m_req     (m_req),
      .m_wr      (m_wr),
      .m_address (m_address),
      .m_dout    (m_dout),
      .s_dout    (s_dout),
      .m_grant   (m_grant),
      .m_din     (m_din),
      .m_err     (m_err),
      .s_sel     (s_sel),
      .s_address (s_address),
      .s_wr      (s_wr),
      .s_din     (s_din)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_mst(input int i, input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d);
      mst_addr[i]          = a;
      m_address[i*AW +: AW] = a;
      m_wr[i]              = wr;
      m_dout[i*DW +: DW]   = d;
   endtask

   // Slave model: region index is the address divided by the 32-byte region size.
   function automatic logic [DW:0] exp_ret(input logic [AW-1:0] a);
      int idx;
      idx = int'(a) / 32;
      if (idx < NS) return {1'b0, sdout_m[idx]};
      return {1'b1, {DW{1'b0}}};
   endfunction

   function automatic logic [AW-1:0] addr_of(input logic [NM-1:0] g);
      logic [AW-1:0] a;
      a = '0;
      for (int i = 0; i < NM; i++) begin
         if (g[i]) a = mst_addr[i];
      end
      return a;
   endfunction

   task automatic push_read(input logic [AW-1:0] a);
      exp_q.push_back(exp_ret(a));
   endtask

   task automatic sb_check(input string name);
      logic [DW:0] e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: got empty expected queue, want one entry", name);
      end else begin
         e = exp_q.pop_front();
         chk({name, "_din"}, 64'(m_din), 64'(e[DW-1:0]));
         chk({name, "_err"}, 64'(m_err), 64'(e[DW]));
      end
   endtask

   initial begin
      logic [AW-1:0] a;
      logic [AW-1:0] edge_addr[5];

      sdout_m[0] = 32'hA0A0_A0A0;
      sdout_m[1] = 32'h1234_5678;
      sdout_m[2] = 32'hC0FF_EE02;
      sdout_m[3] = 32'($urandom_range(1, 32'h7FFF_FFFF));
      for (int i = 0; i < NS; i++) s_dout[i*DW +: DW] = sdout_m[i];

      m_req = '0;
      m_wr = '0;
      m_address = '0;
      m_dout = '0;
      set_mst(0, 8'h05, 1'b0, 32'h0);
      set_mst(1, 8'h21, 1'b0, 32'h0);
      set_mst(2, 8'h45, 1'b0, 32'h0);
      set_mst(3, 8'h90, 1'b0, 32'h0);

      // Grant table: each entry's expectation follows from the previous owner.
      vecs[0]  = '{req: 4'b0110, exp_grant: 4'b0010};
      vecs[1]  = '{req: 4'b0100, exp_grant: 4'b0100};
      vecs[2]  = '{req: 4'b0000, exp_grant: 4'b0100};
      vecs[3]  = '{req: 4'b1001, exp_grant: 4'b1000};
      vecs[4]  = '{req: 4'b1001, exp_grant: 4'b1000};
      vecs[5]  = '{req: 4'b0001, exp_grant: 4'b0001};
      vecs[6]  = '{req: 4'b1111, exp_grant: 4'b0001};
      vecs[7]  = '{req: 4'b1110, exp_grant: 4'b0010};
      vecs[8]  = '{req: 4'b0101, exp_grant: 4'b0100};
      vecs[9]  = '{req: 4'b0011, exp_grant: 4'b0001};
      vecs[10] = '{req: 4'b0000, exp_grant: 4'b0001};

      // Reset held for two cycles.
      reset = 1'b1;
      step();
      step();
      chk("rst_grant", 64'(m_grant), 64'(4'b0001));
      chk("rst_din", 64'(m_din), 64'h0);
      chk("rst_err", 64'(m_err), 64'h0);
      reset = 1'b0;
      #1;
      chk("rel_din", 64'(m_din), 64'h0);
      cur_grant = 4'b0001;
      push_read(addr_of(cur_grant));
      step();
      sb_check("park_rd");
      chk("park_grant", 64'(m_grant), 64'(4'b0001));

      // Table-driven arbitration with read returns scored every cycle.
      for (int v = 0; v < 11; v++) begin
         m_req = vecs[v].req;
         push_read(addr_of(cur_grant));
         step();
         sb_check($sformatf("tbl%0d_rd", v));
         chk($sformatf("tbl%0d_grant", v), 64'(m_grant), 64'(vecs[v].exp_grant));
         cur_grant = vecs[v].exp_grant;
      end

      // Write by master 2 reaches slave 2 combinationally.
      m_req = 4'b0100;
      step();
      chk("wr_grant", 64'(m_grant), 64'(4'b0100));
      set_mst(2, 8'h45, 1'b1, 32'hDEAD_BEEF);
      #1;
      chk("wr_sel", 64'(s_sel), 64'(4'b0100));
      chk("wr_addr", 64'(s_address), 64'h45);
      chk("wr_wr", 64'(s_wr), 64'h1);
      chk("wr_din", 64'(s_din), 64'hDEAD_BEEF);
      set_mst(2, 8'h45, 1'b0, 32'h0);

      // Reads by master 1, including region edges and random addresses.
      m_req = 4'b0010;
      step();
      chk("rd_grant", 64'(m_grant), 64'(4'b0010));
      set_mst(1, 8'h21, 1'b0, 32'h0);
      push_read(8'h21);
      step();
      sb_check("rd_21");
      set_mst(1, 8'h90, 1'b0, 32'h0);
      #1;
      chk("miss_sel", 64'(s_sel), 64'h0);
      chk("miss_wr", 64'(s_wr), 64'h0);
      push_read(8'h90);
      step();
      sb_check("rd_90");

      edge_addr[0] = 8'h00;
      edge_addr[1] = 8'h7F;
      edge_addr[2] = 8'h80;
      edge_addr[3] = 8'hFF;
      edge_addr[4] = 8'h60;
      for (int n = 0; n < 13; n++) begin
         if (n < 5) a = edge_addr[n];
         else a = 8'($urandom_range(0, 255));
         set_mst(1, a, 1'b0, 32'h0);
         push_read(a);
         step();
         sb_check($sformatf("rd_%02h", a));
      end

      // All masters requesting with master 0 owning the bus.
      m_req = 4'b0001;
      step();
      chk("hold_start", 64'(m_grant), 64'(4'b0001));
      m_req = 4'b1111;
      for (int k = 1; k <= 40; k++) begin
         step();
`ifdef BUS_TIMEOUT_EN
         if (k < 16) chk($sformatf("hold%0d", k), 64'(m_grant), 64'(4'b0001));
         else if (k < 32) chk($sformatf("hold%0d", k), 64'(m_grant), 64'(4'b0010));
         else chk($sformatf("hold%0d", k), 64'(m_grant), 64'(4'b0100));
`else
         chk($sformatf("hold%0d", k), 64'(m_grant), 64'(4'b0001));
`endif
      end

      // Reset while master 3 is reading, then master 3 wins the bus back.
      m_req = 4'b1000;
      set_mst(3, 8'h61, 1'b0, 32'h0);
      step();
      step();
      chk("m3_grant", 64'(m_grant), 64'(4'b1000));
      reset = 1'b1;
      step();
      chk("mid_rst_grant", 64'(m_grant), 64'(4'b0001));
      chk("mid_rst_din", 64'(m_din), 64'h0);
      chk("mid_rst_err", 64'(m_err), 64'h0);
      reset = 1'b0;
      step();
      chk("reacq_grant", 64'(m_grant), 64'(4'b1000));
      push_read(8'h61);
      step();
      sb_check("reacq_rd");

      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL sb_drain: got %0d leftover entries, want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
